// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module : spi_reg_ctrl
// Desc   : SPI mode-0 target, oversampled on clk, writing five PWM config regs.
//          Optional register readback on cipo when SPI_READBACK_EN is defined.
// Rev    : 1.0
// ============================================================================
module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done
);

  localparam logic [6:0] MAX_ADDR_7 = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_FULL   = 5'd16;
  localparam logic [4:0] CNT_OVRN   = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_hist;
  logic                   ncs_hist;

  // ncs idles high, so its synchroniser resets high to avoid a false select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_hist <= 1'b0;
      ncs_hist  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      ncs_hist  <= ncs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign ncs_fall  = ~ncs_s & ncs_hist;
  assign ncs_rise  = ncs_s & ~ncs_hist;

  state_t state, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ncs_fall) state_next = SHIFT;
      SHIFT:   if (ncs_rise) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic [6:0]  frame_addr;
  logic        write_ok;

  // A bit arriving together with ncs_rise is still shifted before COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (state == IDLE && ncs_fall) begin
      bit_cnt <= '0;
    end else if (state == SHIFT && sclk_rise) begin
      shift_reg <= {shift_reg[14:0], copi_s};
      if (bit_cnt != CNT_OVRN) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  assign frame_addr = shift_reg[14:8];
  assign write_ok   = (state == COMMIT) && (bit_cnt == CNT_FULL) &&
                      shift_reg[15] && (frame_addr <= MAX_ADDR_7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
      txn_done        <= 1'b0;
    end else begin
      txn_done <= write_ok;
      if (write_ok) begin
        case (frame_addr)
          7'd0:    en_reg_out_7_0  <= shift_reg[7:0];
          7'd1:    en_reg_out_15_8 <= shift_reg[7:0];
          7'd2:    en_reg_pwm_7_0  <= shift_reg[7:0];
          7'd3:    en_reg_pwm_15_8 <= shift_reg[7:0];
          7'd4:    pwm_duty_cycle  <= shift_reg[7:0];
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_shift;
  logic       cipo_q;

  assign sclk_fall = ~sclk_s & sclk_hist;
  // Address is complete on the 8th rise: six stored addr bits plus the incoming one.
  assign rd_addr   = {shift_reg[5:0], copi_s};

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr <= MAX_ADDR_7) begin
      case (rd_addr)
        7'd0:    rd_data = en_reg_out_7_0;
        7'd1:    rd_data = en_reg_out_15_8;
        7'd2:    rd_data = en_reg_pwm_7_0;
        7'd3:    rd_data = en_reg_pwm_15_8;
        7'd4:    rd_data = pwm_duty_cycle;
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= 8'h00;
      cipo_q   <= 1'b0;
    end else begin
      if (state == IDLE && ncs_fall)
        tx_shift <= 8'h00;
      else if (state == SHIFT && sclk_rise && bit_cnt == 5'd7)
        tx_shift <= rd_data;
      else if (state == SHIFT && sclk_fall)
        tx_shift <= {tx_shift[6:0], 1'b0};

      if (state_next != SHIFT)
        cipo_q <= 1'b0;
      else if (state == SHIFT && sclk_fall)
        cipo_q <= tx_shift[7];
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_reg_ctrl
// Desc   : Directed SPI frames; txn_done scoreboard plus register snapshots.
// Rev    : 1.0
// ============================================================================
module tb_spi_reg_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int MAX_ADDR    = 4;
  localparam int HALF        = 6;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk  = 1'b0;
  logic       copi  = 1'b0;
  logic       ncs   = 1'b1;
  logic       cipo;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       txn_done;

  spi_reg_ctrl #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(MAX_ADDR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .cipo            (cipo),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .txn_done        (txn_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] exp_reg [0:4];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         rise_cyc = 0;
  logic [7:0] rx;

  function automatic logic [7:0] dut_reg(input int a);
    case (a)
      0:       return en_reg_out_7_0;
      1:       return en_reg_out_15_8;
      2:       return en_reg_pwm_7_0;
      3:       return en_reg_pwm_15_8;
      4:       return pwm_duty_cycle;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 5; a++)
      check($sformatf("%s_reg%0d", tag, a), 32'(dut_reg(a)), 32'(exp_reg[a]));
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_write(input int a, input logic [7:0] d);
    wr_t e;
    e.addr = 3'(a);
    e.data = d;
    exp_q.push_back(e);
    exp_reg[a] = d;
  endtask

  // Sends bits[n-1:0] MSB first; optional reset pulse after bit number rst_after.
  task automatic spi_xfer(input logic [31:0] bits, input int n, input int rst_after,
                          output logic [7:0] rxd);
    rxd = 8'h00;
    ncs = 1'b0;
    wait_clk(HALF);
    for (int k = 0; k < n; k++) begin
      copi = bits[n-1-k];
      wait_clk(HALF);
      sclk = 1'b1;
      if (k >= 8 && k <= 15) rxd = {rxd[6:0], cipo};
      wait_clk(HALF);
      sclk = 1'b0;
      if (k + 1 == rst_after) begin
        wait_clk(2);
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
      end
    end
    wait_clk(HALF);
    ncs      = 1'b1;
    rise_cyc = cyc;
    wait_clk(12);
  endtask

  // Scoreboard monitor: every txn_done pulse must match a queued write.
  always @(negedge clk) begin
    wr_t e;
    if (txn_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL txn_done_unexpected: got pulse at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("commit_reg%0d", e.addr), 32'(dut_reg(int'(e.addr))), 32'(e.data));
        n_checks++;
        if (cyc - rise_cyc > SYNC_STAGES + 2) begin
          n_fail++;
          $display("FAIL commit_latency: got %0d clk, expected <= %0d",
                   cyc - rise_cyc, SYNC_STAGES + 2);
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < 5; a++) exp_reg[a] = 8'h00;
    wait_clk(5);
    check("reset_cipo", 32'(cipo), 32'h0);
    check("reset_txn_done", 32'(txn_done), 32'h0);
    rst_n = 1'b1;
    wait_clk(5);
    check_all("reset");

    // Basic writes, including the highest address and an overwrite
    expect_write(0, 8'hF0); spi_xfer(32'h80F0, 16, -1, rx);
    expect_write(4, 8'hC0); spi_xfer(32'h84C0, 16, -1, rx);
    expect_write(1, 8'h3C); spi_xfer(32'h813C, 16, -1, rx);
    expect_write(1, 8'h5A); spi_xfer(32'h815A, 16, -1, rx);
    check("pending_after_writes", 32'(exp_q.size()), 32'h0);
    check_all("writes");

    // Out-of-range address and read frame: discarded
    spi_xfer(32'h85AA, 16, -1, rx);
    spi_xfer(32'h7F55, 16, -1, rx);
    check("pending_after_discard", 32'(exp_q.size()), 32'h0);
    check_all("discard");

    // Reset between frames
    rst_n = 1'b0;
    for (int a = 0; a < 5; a++) exp_reg[a] = 8'h00;
    wait_clk(2);
    check_all("midrun_reset");
    check("midrun_reset_cipo", 32'(cipo), 32'h0);
    check("midrun_reset_txn_done", 32'(txn_done), 32'h0);
    rst_n = 1'b1;
    wait_clk(4);

    // Short and long frames discarded, then a correct one lands
    expect_write(4, 8'h77); spi_xfer(32'h8477, 16, -1, rx);
    spi_xfer(32'h4119, 15, -1, rx);
    spi_xfer(32'h10466, 17, -1, rx);
    check("pending_after_bad_len", 32'(exp_q.size()), 32'h0);
    check_all("bad_len");
    expect_write(2, 8'h33); spi_xfer(32'h8233, 16, -1, rx);
    check_all("good_len");

    // Reset after bit 10 of a frame; remainder must not commit
    spi_xfer(32'h83FF, 16, 10, rx);
    for (int a = 0; a < 5; a++) exp_reg[a] = 8'h00;
    check("pending_after_frame_reset", 32'(exp_q.size()), 32'h0);
    check_all("frame_reset");
    expect_write(3, 8'hFF); spi_xfer(32'h83FF, 16, -1, rx);
    check_all("after_frame_reset");

    // Readback of reg 1
    expect_write(1, 8'h81); spi_xfer(32'h8181, 16, -1, rx);
    spi_xfer(32'h0100, 16, -1, rx);
`ifdef SPI_READBACK_EN
    check("readback_data", 32'(rx), 32'h81);
`else
    check("readback_data", 32'(rx), 32'h00);
`endif
    check("cipo_idle", 32'(cipo), 32'h0);
    check("pending_final", 32'(exp_q.size()), 32'h0);
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
